// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: prefetches next-line sprite rows from sprite RAM port 2
// into a double-buffered line buffer and serves one palette index per pixel.
module sprite_line_fetcher #(
    parameter int         NUM_SLOTS  = 4,
    parameter logic [3:0] TRANSP_IDX = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_write,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_writedata,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    output logic [10:0] ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [1:0]  ram_byteenable,
    output logic [15:0] ram_writedata,
    output logic        ram_clken,
    input  logic [15:0] ram_readdata,
    input  logic        draw_valid,
    input  logic [9:0]  draw_x,
    output logic        pix_valid,
    output logic        pix_hit,
    output logic [3:0]  pix_index,
    output logic        busy,
    output logic        overrun
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DRAIN} state_t;

    logic          sh_en  [NUM_SLOTS];
    logic [9:0]    sh_x   [NUM_SLOTS];
    logic [9:0]    sh_y   [NUM_SLOTS];
    logic [2:0]    sh_img [NUM_SLOTS];
    logic          act_en [NUM_SLOTS];
    logic [9:0]    act_x  [NUM_SLOTS];
    logic [9:0]    act_y  [NUM_SLOTS];
    logic [2:0]    act_img[NUM_SLOTS];

    logic          fetch_bank;
    logic          disp_bank;
    logic          bank_valid[2][NUM_SLOTS];
    logic [9:0]    bank_x    [2][NUM_SLOTS];
    logic [127:0]  bank_pix  [2][NUM_SLOTS];

    state_t        state;
    logic [SW-1:0] slot;
    logic [2:0]    word;
    logic [9:0]    line_q;
    logic [4:0]    row_q;

    logic          cur_en;
    logic [9:0]    cur_x;
    logic [9:0]    cur_y;
    logic [2:0]    cur_img;
    logic [10:0]   row_calc;
    logic          cap_en;
    logic [2:0]    cap_word;
    logic          hit;
    logic [3:0]    hit_idx;
    logic          unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_writedata[30:23];

    assign ram_write      = 1'b0;
    assign ram_byteenable = 2'b11;
    assign ram_writedata  = 16'd0;
    assign ram_clken      = 1'b1;
    assign busy           = (state != IDLE);
    assign disp_bank      = ~fetch_bank;

    assign cur_en   = act_en[slot];
    assign cur_x    = act_x[slot];
    assign cur_y    = act_y[slot];
    assign cur_img  = act_img[slot];
    assign row_calc = {1'b0, line_q} - {1'b0, cur_y};

    // Read data trails the address by one cycle; DRAIN takes the last word.
    assign cap_en   = !line_start && ((state == ISSUE && word != 3'd0) || state == DRAIN);
    assign cap_word = (state == DRAIN) ? 3'd7 : word - 3'd1;

    // Shadow registers take cfg writes; frame_start publishes them (new write wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                sh_en[s]   <= 1'b0;
                sh_x[s]    <= 10'd0;
                sh_y[s]    <= 10'd0;
                sh_img[s]  <= 3'd0;
                act_en[s]  <= 1'b0;
                act_x[s]   <= 10'd0;
                act_y[s]   <= 10'd0;
                act_img[s] <= 3'd0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (cfg_write && cfg_addr == 3'(s)) begin
                    sh_en[s]  <= cfg_writedata[31];
                    sh_x[s]   <= cfg_writedata[9:0];
                    sh_y[s]   <= cfg_writedata[19:10];
                    sh_img[s] <= cfg_writedata[22:20];
                end
                if (frame_start) begin
                    if (cfg_write && cfg_addr == 3'(s)) begin
                        act_en[s]  <= cfg_writedata[31];
                        act_x[s]   <= cfg_writedata[9:0];
                        act_y[s]   <= cfg_writedata[19:10];
                        act_img[s] <= cfg_writedata[22:20];
                    end else begin
                        act_en[s]  <= sh_en[s];
                        act_x[s]   <= sh_x[s];
                        act_y[s]   <= sh_y[s];
                        act_img[s] <= sh_img[s];
                    end
                end
            end
        end
    end

    // Fetch FSM: bank swap on line_start, per-slot range check, 8-word burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            slot           <= '0;
            word           <= 3'd0;
            line_q         <= 10'd0;
            row_q          <= 5'd0;
            fetch_bank     <= 1'b0;
            ram_address    <= 11'd0;
            ram_chipselect <= 1'b0;
            overrun        <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    bank_valid[b][s] <= 1'b0;
                    bank_x[b][s]     <= 10'd0;
                end
            end
        end else if (line_start) begin
            fetch_bank     <= ~fetch_bank;
            line_q         <= line_y;
            slot           <= '0;
            word           <= 3'd0;
            state          <= CHECK;
            ram_chipselect <= 1'b0;
            if (state != IDLE) begin
                overrun <= 1'b1;
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                bank_valid[~fetch_bank][s] <= 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                CHECK: begin
                    if (cur_en && row_calc < 11'd32) begin
                        row_q          <= row_calc[4:0];
                        ram_address    <= {cur_img, row_calc[4:0], 3'd0};
                        ram_chipselect <= 1'b1;
                        word           <= 3'd0;
                        state          <= ISSUE;
                    end else if (slot == LAST) begin
                        state <= IDLE;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                ISSUE: begin
                    if (word == 3'd7) begin
                        ram_chipselect <= 1'b0;
                        state          <= DRAIN;
                    end else begin
                        word        <= word + 3'd1;
                        ram_address <= {cur_img, row_q, word + 3'd1};
                    end
                end
                DRAIN: begin
                    bank_valid[fetch_bank][slot] <= 1'b1;
                    bank_x[fetch_bank][slot]     <= cur_x;
                    if (slot == LAST) begin
                        state <= IDLE;
                    end else begin
                        slot  <= slot + 1'b1;
                        state <= CHECK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel storage carries no reset; the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            bank_pix[fetch_bank][slot][{cap_word, 4'd0} +: 16] <= ram_readdata;
        end
    end

    // Priority select: scan high to low so the lowest-numbered opaque slot wins.
    always_comb begin
        logic [10:0] dx;
        logic [3:0]  nib;
        hit     = 1'b0;
        hit_idx = TRANSP_IDX;
        dx      = 11'd0;
        nib     = 4'd0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            dx  = {1'b0, draw_x} - {1'b0, bank_x[disp_bank][s]};
            nib = bank_pix[disp_bank][s][{dx[4:0], 2'b00} +: 4];
            if (bank_valid[disp_bank][s] && dx < 11'd32 && nib != TRANSP_IDX) begin
                hit     = 1'b1;
                hit_idx = nib;
            end
        end
    end

    // Registered pixel output, one cycle behind draw_x.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_hit   <= 1'b0;
            pix_index <= 4'd0;
        end else begin
            pix_valid <= draw_valid;
            pix_hit   <= draw_valid && hit;
            pix_index <= (draw_valid && hit) ? hit_idx : TRANSP_IDX;
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: RAM model, config/line model and
// scoreboards for issued addresses and rendered pixels.
module tb_sprite_line_fetcher;

    localparam int         NS     = 4;
    localparam logic [3:0] TRANSP = 4'd0;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_write;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_writedata;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  line_y;
    logic [10:0] ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [1:0]  ram_byteenable;
    logic [15:0] ram_writedata;
    logic        ram_clken;
    logic [15:0] ram_readdata;
    logic        draw_valid;
    logic [9:0]  draw_x;
    logic        pix_valid;
    logic        pix_hit;
    logic [3:0]  pix_index;
    logic        busy;
    logic        overrun;

    sprite_line_fetcher #(.NUM_SLOTS(NS), .TRANSP_IDX(TRANSP)) dut (
        .clk(clk), .reset(reset),
        .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_writedata(cfg_writedata),
        .frame_start(frame_start), .line_start(line_start), .line_y(line_y),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata),
        .draw_valid(draw_valid), .draw_x(draw_x),
        .pix_valid(pix_valid), .pix_hit(pix_hit), .pix_index(pix_index),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2048];
    always @(posedge clk) ram_readdata <= mem[ram_address];

    int checks = 0;
    int errors = 0;
    int reads = 0;
    int exp_reads = 0;
    int busy_cycles = 0;

    logic [10:0] addr_q[$];
    logic [4:0]  pix_q[$];
    int          pxx_q[$];

    logic       sh_en [NS];
    logic [9:0] sh_x  [NS];
    logic [9:0] sh_y  [NS];
    logic [2:0] sh_img[NS];
    logic       a_en  [NS];
    logic [9:0] a_x   [NS];
    logic [9:0] a_y   [NS];
    logic [2:0] a_img [NS];
    logic       f_on  [NS];
    logic [9:0] f_x   [NS];
    logic [2:0] f_img [NS];
    logic [4:0] f_row [NS];
    logic       d_on  [NS];
    logic [9:0] d_x   [NS];
    logic [2:0] d_img [NS];
    logic [4:0] d_row [NS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_pix(input int x);
        logic [4:0]  r;
        logic [10:0] dx;
        logic [15:0] w;
        logic [3:0]  nib;
        r = {1'b0, TRANSP};
        for (int s = NS - 1; s >= 0; s--) begin
            dx = 11'(x) - {1'b0, d_x[s]};
            if (d_on[s] && dx < 11'd32) begin
                w   = mem[{d_img[s], d_row[s], dx[4:2]}];
                nib = 4'(w >> {dx[1:0], 2'b00});
                if (nib != TRANSP) r = {1'b1, nib};
            end
        end
        return r;
    endfunction

    // Scoreboard side: pop expected address / pixel when the DUT produces one.
    always @(negedge clk) begin
        if (ram_chipselect) begin
            reads++;
            checks++;
            assert (addr_q.size() != 0) else begin
                errors++;
                $error("FAIL addr_extra: observed %0h expected none", ram_address);
            end
            if (addr_q.size() != 0) chk("ram_address", 32'(ram_address), 32'(addr_q.pop_front()));
        end
        if (busy) busy_cycles++;
        if (pix_valid) begin
            checks++;
            assert (pix_q.size() != 0) else begin
                errors++;
                $error("FAIL pix_extra: observed %0h expected none", {pix_hit, pix_index});
            end
            if (pix_q.size() != 0)
                chk($sformatf("pix x=%0d", pxx_q.pop_front()), 32'({pix_hit, pix_index}),
                    32'(pix_q.pop_front()));
        end else begin
            chk("pix_idle", 32'({pix_hit, pix_index}), 32'({1'b0, TRANSP}));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int s, input bit en, input int x, input int y, input int img);
        if (s < NS) begin
            sh_en[s] = en; sh_x[s] = 10'(x); sh_y[s] = 10'(y); sh_img[s] = 3'(img);
        end
        cfg_write = 1'b1;
        cfg_addr = 3'(s);
        cfg_writedata = {en, 8'd0, 3'(img), 10'(y), 10'(x)};
        tick();
        cfg_write = 1'b0;
    endtask

    task automatic frame();
        for (int s = 0; s < NS; s++) begin
            a_en[s] = sh_en[s]; a_x[s] = sh_x[s]; a_y[s] = sh_y[s]; a_img[s] = sh_img[s];
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input int y, input bit abort);
        logic [10:0] row;
        for (int s = 0; s < NS; s++) begin
            d_on[s] = abort ? 1'b0 : f_on[s];
            d_x[s] = f_x[s]; d_img[s] = f_img[s]; d_row[s] = f_row[s];
        end
        if (abort) begin
            while (addr_q.size() > 1) void'(addr_q.pop_back());
            exp_reads = addr_q.size();
        end else begin
            chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);
            exp_reads = 0;
        end
        for (int s = 0; s < NS; s++) begin
            row = 11'(y) - {1'b0, a_y[s]};
            f_on[s] = a_en[s] && row < 11'd32;
            f_x[s] = a_x[s]; f_img[s] = a_img[s]; f_row[s] = row[4:0];
            if (f_on[s]) begin
                for (int w = 0; w < 8; w++) addr_q.push_back({a_img[s], row[4:0], 3'(w)});
                exp_reads += 8;
            end
        end
        reads = 0;
        busy_cycles = 0;
        line_y = 10'(y);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("fetch_done", 32'(busy), 32'd0);
        chk("read_count", 32'(reads), 32'(exp_reads));
    endtask

    task automatic draw(input int x0, input int n);
        for (int i = 0; i < n; i++) begin
            pxx_q.push_back(x0 + i);
            pix_q.push_back(exp_pix(x0 + i));
            draw_valid = 1'b1;
            draw_x = 10'(x0 + i);
            tick();
        end
        draw_valid = 1'b0;
        tick(2);
    endtask

    task automatic draw_const(input int x, input logic [4:0] e);
        pxx_q.push_back(x);
        pix_q.push_back(e);
        draw_valid = 1'b1;
        draw_x = 10'(x);
        tick();
        draw_valid = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            sh_en[s] = 0; sh_x[s] = 0; sh_y[s] = 0; sh_img[s] = 0;
            a_en[s] = 0; a_x[s] = 0; a_y[s] = 0; a_img[s] = 0;
            f_on[s] = 0; f_x[s] = 0; f_img[s] = 0; f_row[s] = 0;
            d_on[s] = 0; d_x[s] = 0; d_img[s] = 0; d_row[s] = 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'((i * 40503) ^ (i >> 3) ^ 16'h1234);
        mem[11'h200] = 16'h4321;
        mem[11'h300] = 16'h0A0B;
        mem[11'h400] = 16'h5555;
        model_reset();
        reset = 1'b1;
        cfg_write = 0; cfg_addr = 0; cfg_writedata = 0;
        frame_start = 0; line_start = 0; line_y = 0;
        draw_valid = 0; draw_x = 0;
        tick(3);
        chk("rst_chipselect", 32'(ram_chipselect), 0);
        chk("rst_address", 32'(ram_address), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_pix", 32'({pix_valid, pix_hit, pix_index}), 0);
        chk("rst_byteenable", 32'(ram_byteenable), 32'h3);
        chk("rst_clken", 32'(ram_clken), 1);
        chk("rst_write", 32'({ram_write, ram_writedata}), 0);
        reset = 1'b0;
        tick();

        // single sprite fetch and draw
        cfg(0, 1, 100, 50, 2);
        frame();
        pulse_line(50, 0);
        wait_idle();
        checks++;
        assert (busy_cycles >= 10 && busy_cycles <= 10 * NS + 1) else begin
            errors++;
            $error("FAIL busy_cycles: observed %0d expected 10..%0d", busy_cycles, 10 * NS + 1);
        end
        pulse_line(51, 0);
        draw_const(99, 5'h00);
        draw_const(100, 5'h11);
        draw_const(101, 5'h12);
        draw_const(102, 5'h13);
        draw_const(103, 5'h14);
        draw(90, 50);
        wait_idle();

        // vertical range boundaries
        pulse_line(49, 0);
        wait_idle();
        pulse_line(82, 0);
        draw(90, 50);
        wait_idle();
        pulse_line(81, 0);
        draw(90, 50);
        wait_idle();
        pulse_line(0, 0);
        draw(90, 50);
        wait_idle();

        // overlap priority
        cfg(0, 1, 200, 10, 3);
        cfg(1, 1, 200, 10, 4);
        cfg(6, 1, 0, 0, 7);
        frame();
        pulse_line(10, 0);
        wait_idle();
        pulse_line(11, 0);
        draw_const(200, 5'h1B);
        draw_const(201, 5'h15);
        draw_const(202, 5'h1A);
        draw_const(203, 5'h15);
        draw(190, 50);
        wait_idle();

        // overrun: second line_start 5 cycles after the first
        cfg(0, 1, 0, 20, 0);
        cfg(1, 1, 40, 20, 1);
        cfg(2, 1, 80, 20, 5);
        cfg(3, 1, 120, 20, 6);
        frame();
        pulse_line(20, 0);
        tick(4);
        pulse_line(21, 1);
        chk("overrun_set", 32'(overrun), 1);
        draw(0, 160);
        wait_idle();
        pulse_line(22, 0);
        draw(0, 160);
        wait_idle();
        chk("overrun_sticky", 32'(overrun), 1);

        // shadow write mid-frame takes effect only at frame_start
        cfg(0, 1, 100, 50, 2);
        cfg(1, 0, 0, 0, 0);
        cfg(2, 0, 0, 0, 0);
        cfg(3, 0, 0, 0, 0);
        frame();
        pulse_line(50, 0);
        wait_idle();
        cfg(0, 1, 300, 50, 2);
        pulse_line(51, 0);
        draw_const(101, 5'h12);
        draw_const(300, 5'h00);
        draw(295, 10);
        wait_idle();
        frame();
        pulse_line(50, 0);
        wait_idle();
        pulse_line(51, 0);
        draw_const(299, 5'h00);
        draw_const(300, 5'h11);
        draw_const(303, 5'h14);
        draw_const(101, 5'h00);
        draw(95, 10);
        wait_idle();

        // right-edge clipping, no wrap
        cfg(0, 1, 1020, 50, 2);
        frame();
        pulse_line(50, 0);
        wait_idle();
        pulse_line(51, 0);
        draw_const(1019, 5'h00);
        draw_const(1020, 5'h11);
        draw_const(1021, 5'h12);
        draw_const(1022, 5'h13);
        draw_const(1023, 5'h14);
        draw(0, 8);
        wait_idle();

        // reset in the middle of a burst
        cfg(0, 1, 100, 50, 2);
        frame();
        pulse_line(50, 0);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_chipselect", 32'(ram_chipselect), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_overrun", 32'(overrun), 0);
        addr_q.delete();
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        pulse_line(51, 0);
        wait_idle();
        draw(95, 10);

        tick(3);
        chk("pix_queue_empty", 32'(pix_q.size()), 0);
        chk("addr_queue_empty", 32'(addr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
